sub16_block_accum: RTL and testbench
====================================

// Module: sub16_block_accum
// PURPOSE
//  Downstream consumer of the 16-bit signed subtractor (sub_16bit_signed).
//  Takes each (result, overflow) difference sample over a valid/ready handshake.
//  Corrects wrapped results to the saturated true value, then accumulates BLOCK_LEN
//  samples into a saturating sum. Emits one block sum with status over an output handshake.
// PARAMETERS
//  WIDTH      16  sample width (signed); matches subtractor result width
//  ACC_WIDTH  24  signed accumulator / out_sum width; must be >= WIDTH
//  BLOCK_LEN  8   samples per block; must be >= 1
//  CNT_W      8   width of out_ovf_cnt
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous, active-high reset
//  clear        in   1          synchronous block abort: discard partial block
//  in_valid     in   1          upstream sample valid
//  in_ready     out  1          block can accept a sample
//  in_diff      in   WIDTH      subtractor result A-B (signed, may be wrapped)
//  in_ovf       in   1          subtractor overflow flag
//  in_a_sign    in   1          sign bit of minuend A (gives saturation direction)
//  out_valid    out  1          block result valid
//  out_ready    in   1          downstream accepts result
//  out_sum      out  ACC_WIDTH  saturated block sum (signed)
//  out_sat      out  1          accumulator saturated at least once in this block
//  out_ovf_cnt  out  CNT_W      count of in_ovf samples in block; saturates at all-ones
//  sticky_ovf   out  1          any in_ovf accepted since rst/clear
// BEHAVIOUR
//  Reset (async) values: state=ACCUM, acc=0, count=0, out_valid=0, out_sum=0,
//   out_sat=0, out_ovf_cnt=0, sticky_ovf=0.
//  States:
//   - ACCUM: in_ready=1, out_valid=0.
//   - OUTPUT: in_ready=0, out_valid=1.
//  in_ready is purely a function of state (no combinational path from out_ready).
//  Accept: in_valid & in_ready. On accept, form corrected sample x:
//   - in_ovf=1: x = in_a_sign ? -2^(WIDTH-1) : 2^(WIDTH-1)-1.
//   - in_ovf=0: x = in_diff.
//  Sum: acc_next = acc + sext(x), computed at ACC_WIDTH+1 bits.
//   - Clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//   - Any clamp sets block sat flag.
//  in_ovf=1 increments the block ovf count (holds at max) and sets sticky_ovf.
//  ACCUM->OUTPUT: on accept when count==BLOCK_LEN-1.
//   - out_sum/out_sat/out_ovf_cnt are loaded from the next-state values on that edge.
//   - out_valid is high the next cycle (latency 1 from the last sample).
//   - acc, count, block flags and ovf count clear on the same edge.
//  OUTPUT: out_* held stable while out_ready=0; in_valid ignored.
//  OUTPUT->ACCUM: on out_valid & out_ready. in_ready=1 the following cycle.
//   - Block period = BLOCK_LEN+1 cycles with no backpressure.
//  clear=1 (any state):
//   - Next edge: ACCUM, acc/count/flags/ovf count/sticky_ovf=0, out_valid=0.
//   - Pending output is dropped.
//   - clear beats a simultaneous accept; that sample is lost.
//  rst beats everything; asserting rst mid-OUTPUT drops out_valid immediately.
//  BLOCK_LEN=1: every accepted sample produces an output.
// TESTING (BLOCK_LEN=4 unless noted)
//  1. Samples 1,-1,100,-32768 (no ovf) -> out_sum=-32668, out_sat=0, out_ovf_cnt=0.
//  2. Four samples in_diff=0x8000, in_ovf=1, in_a_sign=0 (A=32767,B=-1)
//     -> out_sum=131068, out_ovf_cnt=4, sticky_ovf=1.
//     Same with in_a_sign=1 -> out_sum=-131072.
//  3. ACC_WIDTH=17, four corrected +32767 samples -> out_sum=65535, out_sat=1.
//  4. out_ready=0 for 5 cycles in OUTPUT -> out_valid and out_* stable, in_ready=0,
//     in_valid pulses not counted.
//     Release -> next block starts clean and sums correctly.
//  5. Two samples of 7, then clear, then four samples of 10 -> out_sum=40, sticky_ovf=0.
//     Async rst asserted during OUTPUT -> out_valid=0 without waiting for a clock edge.
//  6. Continuous in_valid, out_ready=1 -> one out_valid pulse every 5 cycles.
//     Compare against a reference model over 200 random subtractor outputs.

Source files
------------

// File: rtl/sub16_block_accum.sv
// sub16_block_accum: consumes (difference, overflow) samples from a 16-bit
// signed subtractor. Wrapped differences are replaced by their saturated true
// value, BLOCK_LEN samples are summed into a saturating accumulator, and each
// block result is presented over a valid/ready output handshake.
module sub16_block_accum #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_diff,
  input  logic                 in_ovf,
  input  logic                 in_a_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_sat,
  output logic [CNT_W-1:0]     out_ovf_cnt,
  output logic                 sticky_ovf
);

  // Sample counter wide enough for BLOCK_LEN-1, at least one bit.
  localparam int CB = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CB-1:0] LAST_IDX = CB'(BLOCK_LEN - 1);

  localparam logic [WIDTH-1:0]     X_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     X_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CB-1:0]        count_q, count_d;
  logic                 blk_sat_q, blk_sat_d;
  logic [CNT_W-1:0]     blk_ovf_cnt_q, blk_ovf_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_sat_q, out_sat_d;
  logic [CNT_W-1:0]     out_ovf_cnt_q, out_ovf_cnt_d;
  logic                 sticky_ovf_q, sticky_ovf_d;

  logic [WIDTH-1:0]     x;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 clamp_hi, clamp_lo;
  logic [ACC_WIDTH-1:0] acc_clamped;
  logic                 sat_next;
  logic [CNT_W-1:0]     ovf_cnt_next;
  logic                 accept;

  // Ready depends only on state, so there is no path from out_ready to in_ready.
  assign in_ready = (state_q == S_ACCUM);
  assign accept   = in_valid & in_ready;

  // Datapath: corrected sample, one-bit-wider sum, clamp and per-block counters.
  // NOTE: combinational blocks use blocking (=) assignments so later lines see
  // the values computed above them; sequential blocks use non-blocking (<=).
  always_comb begin
    x            = in_ovf ? (in_a_sign ? X_MIN : X_MAX) : in_diff;
    sum_wide     = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH + 1 - WIDTH){x[WIDTH-1]}}, x};
    // Top two bits disagree only when the true sum left the ACC_WIDTH range.
    clamp_hi     = ~sum_wide[ACC_WIDTH] &  sum_wide[ACC_WIDTH-1];
    clamp_lo     =  sum_wide[ACC_WIDTH] & ~sum_wide[ACC_WIDTH-1];
    acc_clamped  = clamp_hi ? ACC_MAX : (clamp_lo ? ACC_MIN : sum_wide[ACC_WIDTH-1:0]);
    sat_next     = blk_sat_q | clamp_hi | clamp_lo;
    ovf_cnt_next = (in_ovf && (blk_ovf_cnt_q != {CNT_W{1'b1}}))
                 ? blk_ovf_cnt_q + CNT_W'(1) : blk_ovf_cnt_q;
  end

  // Next-state logic for the ACCUM/OUTPUT controller and all registered state.
  // NOTE: every target gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    count_d       = count_q;
    blk_sat_d     = blk_sat_q;
    blk_ovf_cnt_d = blk_ovf_cnt_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_sat_d     = out_sat_q;
    out_ovf_cnt_d = out_ovf_cnt_q;
    sticky_ovf_d  = sticky_ovf_q;

    unique case (state_q)
      S_ACCUM: begin
        if (accept) begin
          sticky_ovf_d = sticky_ovf_q | in_ovf;
          if (count_q == LAST_IDX) begin
            // Last sample of the block: publish results and start a fresh block.
            state_d       = S_OUTPUT;
            out_valid_d   = 1'b1;
            out_sum_d     = acc_clamped;
            out_sat_d     = sat_next;
            out_ovf_cnt_d = ovf_cnt_next;
            acc_d         = '0;
            count_d       = '0;
            blk_sat_d     = 1'b0;
            blk_ovf_cnt_d = '0;
          end else begin
            acc_d         = acc_clamped;
            count_d       = count_q + CB'(1);
            blk_sat_d     = sat_next;
            blk_ovf_cnt_d = ovf_cnt_next;
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d     = S_ACCUM;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_ACCUM;
    endcase

    // Abort wins over any accept or handshake in the same cycle.
    if (clear) begin
      state_d       = S_ACCUM;
      acc_d         = '0;
      count_d       = '0;
      blk_sat_d     = 1'b0;
      blk_ovf_cnt_d = '0;
      out_valid_d   = 1'b0;
      sticky_ovf_d  = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_ACCUM;
      acc_q         <= '0;
      count_q       <= '0;
      blk_sat_q     <= 1'b0;
      blk_ovf_cnt_q <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_sat_q     <= 1'b0;
      out_ovf_cnt_q <= '0;
      sticky_ovf_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      blk_sat_q     <= blk_sat_d;
      blk_ovf_cnt_q <= blk_ovf_cnt_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_sat_q     <= out_sat_d;
      out_ovf_cnt_q <= out_ovf_cnt_d;
      sticky_ovf_q  <= sticky_ovf_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_sat     = out_sat_q;
  assign out_ovf_cnt = out_ovf_cnt_q;
  assign sticky_ovf  = sticky_ovf_q;

endmodule

// File: tb/tb_sub16_block_accum.sv
// Directed bench for sub16_block_accum. Three instances share stimulus where
// their timing matches: u_main (BLOCK_LEN=4, ACC_WIDTH=24), u_nar
// (BLOCK_LEN=4, ACC_WIDTH=17, CNT_W=2) for accumulator and ovf-count
// saturation, and u_one (BLOCK_LEN=1) with its own handshake signals.
module tb_sub16_block_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_diff = '0;
  logic        in_ovf = 1'b0;
  logic        in_a_sign = 1'b0;
  logic        out_ready = 1'b0;

  logic        m_in_ready, m_out_valid, m_out_sat, m_sticky;
  logic [23:0] m_out_sum;
  logic [7:0]  m_out_cnt;

  logic        n_in_ready, n_out_valid, n_out_sat, n_sticky;
  logic [16:0] n_out_sum;
  logic [1:0]  n_out_cnt;

  logic        o_in_valid = 1'b0;
  logic        o_out_ready = 1'b0;
  logic        o_in_ready, o_out_valid, o_out_sat, o_sticky;
  logic [23:0] o_out_sum;
  logic [7:0]  o_out_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub16_block_accum #(.WIDTH(16), .ACC_WIDTH(24), .BLOCK_LEN(4), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_diff(in_diff), .in_ovf(in_ovf), .in_a_sign(in_a_sign),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_sum(m_out_sum),
    .out_sat(m_out_sat), .out_ovf_cnt(m_out_cnt), .sticky_ovf(m_sticky));

  sub16_block_accum #(.WIDTH(16), .ACC_WIDTH(17), .BLOCK_LEN(4), .CNT_W(2)) u_nar (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_diff(in_diff), .in_ovf(in_ovf), .in_a_sign(in_a_sign),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
    .out_sat(n_out_sat), .out_ovf_cnt(n_out_cnt), .sticky_ovf(n_sticky));

  sub16_block_accum #(.WIDTH(16), .ACC_WIDTH(24), .BLOCK_LEN(1), .CNT_W(8)) u_one (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_diff(in_diff), .in_ovf(in_ovf), .in_a_sign(in_a_sign),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_sum(o_out_sum),
    .out_sat(o_out_sat), .out_ovf_cnt(o_out_cnt), .sticky_ovf(o_sticky));

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample on the shared bus once u_main is ready (bounded wait).
  task automatic send(input logic [15:0] d, input logic ovf, input logic a_sign);
    int n = 0;
    while (!m_in_ready && n < 20) begin
      step();
      n++;
    end
    if (!m_in_ready) check("send_timeout", longint'(m_in_ready), 1);
    in_valid  = 1'b1;
    in_diff   = d;
    in_ovf    = ovf;
    in_a_sign = a_sign;
    step();
    in_valid  = 1'b0;
    in_ovf    = 1'b0;
    in_a_sign = 1'b0;
  endtask

  // Complete the output handshake with a one-cycle out_ready pulse.
  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic longint clampv(input longint v, input int aw);
    longint hi = (longint'(1) <<< (aw - 1)) - 1;
    longint lo = -(longint'(1) <<< (aw - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  initial begin
    // Reset state.
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_sum",   $signed(m_out_sum), 0);
    check("rst_out_sat",   m_out_sat, 0);
    check("rst_out_cnt",   m_out_cnt, 0);
    check("rst_sticky",    m_sticky, 0);
    check("rst_in_ready",  m_in_ready, 1);

    // BLOCK_LEN=1: a single sample produces an output on the next cycle.
    in_diff    = 16'hFFFB;  // -5
    o_in_valid = 1'b1;
    step();
    o_in_valid = 1'b0;
    check("one_out_valid", o_out_valid, 1);
    check("one_out_sum",   $signed(o_out_sum), -5);
    check("one_in_ready",  o_in_ready, 0);
    o_out_ready = 1'b1;
    step();
    o_out_ready = 1'b0;
    check("one_back_valid", o_out_valid, 0);
    check("one_back_ready", o_in_ready, 1);

    // 1: plain samples, no overflow.
    send(16'd1, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'd100, 1'b0, 1'b0);
    check("t1_not_yet_valid", m_out_valid, 0);
    send(16'h8000, 1'b0, 1'b0);
    check("t1_out_valid", m_out_valid, 1);
    check("t1_out_sum",   $signed(m_out_sum), -32668);
    check("t1_out_sat",   m_out_sat, 0);
    check("t1_out_cnt",   m_out_cnt, 0);
    check("t1_nar_sum",   $signed(n_out_sum), -32668);
    check("t1_sticky",    m_sticky, 0);
    drain();
    check("t1_drained_valid", m_out_valid, 0);
    check("t1_drained_ready", m_in_ready, 1);

    // 2/3: overflowed samples corrected to +32767; narrow accumulator clamps.
    repeat (4) send(16'h8000, 1'b1, 1'b0);
    check("t2p_out_sum", $signed(m_out_sum), 131068);
    check("t2p_out_cnt", m_out_cnt, 4);
    check("t2p_out_sat", m_out_sat, 0);
    check("t2p_sticky",  m_sticky, 1);
    check("t3_nar_sum",  $signed(n_out_sum), 65535);
    check("t3_nar_sat",  n_out_sat, 1);
    check("t3_nar_cnt",  n_out_cnt, 3);
    drain();
    repeat (4) send(16'h7FFF, 1'b1, 1'b1);
    check("t2n_out_sum", $signed(m_out_sum), -131072);
    check("t2n_out_cnt", m_out_cnt, 4);
    check("t2n_nar_sum", $signed(n_out_sum), -65536);
    check("t2n_nar_sat", n_out_sat, 1);

    // 4: backpressure for 5 cycles with in_valid pulses that must be ignored.
    in_diff = 16'd50;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
      check("t4_hold_valid", m_out_valid, 1);
      check("t4_hold_sum",   $signed(m_out_sum), -131072);
      check("t4_hold_cnt",   m_out_cnt, 4);
      check("t4_hold_ready", m_in_ready, 0);
      check("t4_hold_nar",   $signed(n_out_sum), -65536);
    end
    in_valid = 1'b0;
    drain();
    check("t4_rel_ready", m_in_ready, 1);
    send(16'd1, 1'b0, 1'b0);
    send(16'd2, 1'b0, 1'b0);
    send(16'd3, 1'b0, 1'b0);
    send(16'd4, 1'b0, 1'b0);
    check("t4_next_sum", $signed(m_out_sum), 10);
    check("t4_next_cnt", m_out_cnt, 0);
    check("t4_next_sat", m_out_sat, 0);
    drain();

    // 5: partial block aborted by clear; the sample offered with clear is lost.
    send(16'd7, 1'b0, 1'b0);
    send(16'd7, 1'b0, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_diff  = 16'd1000;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5_clr_sticky", m_sticky, 0);
    check("t5_clr_ready",  m_in_ready, 1);
    repeat (4) send(16'd10, 1'b0, 1'b0);
    check("t5_out_sum", $signed(m_out_sum), 40);
    check("t5_sticky",  m_sticky, 0);
    // Async reset in OUTPUT drops out_valid without a clock edge.
    check("t5_pre_rst_valid", m_out_valid, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid",     m_out_valid, 0);
    check("t5_rst_nar_valid", n_out_valid, 0);
    check("t5_rst_sum",       $signed(m_out_sum), 0);
    step();
    rst = 1'b0;
    step();

    // 6: streaming random samples compared against an independent model.
    begin
      int     phase = 0;
      int     accepted = 0;
      int     pulses = 0;
      int     guard = 0;
      longint s24 = 0, s17 = 0;
      longint e24 = 0, e17 = 0;
      bit     sat17 = 0, esat17 = 0;
      int     ocnt = 0, eocnt = 0;
      out_ready = 1'b1;
      while ((accepted < 200 || phase != 0) && guard < 1000) begin
        guard++;
        check("t6_in_ready",  m_in_ready, (phase < 4) ? 1 : 0);
        check("t6_out_valid", m_out_valid, (phase == 4) ? 1 : 0);
        if (phase == 4) begin
          pulses++;
          check("t6_sum24", $signed(m_out_sum), e24);
          check("t6_sum17", $signed(n_out_sum), e17);
          check("t6_sat17", n_out_sat, esat17);
          check("t6_cnt8",  m_out_cnt, eocnt);
          check("t6_cnt2",  n_out_cnt, (eocnt > 3) ? 3 : eocnt);
          in_valid = 1'b1;  // offered while not ready; must not be taken
          phase = 0;
        end else if (accepted < 200) begin
          logic signed [15:0] ds;
          longint x;
          in_diff   = 16'($urandom);
          in_ovf    = ($urandom_range(0, 3) == 0);
          in_a_sign = 1'($urandom);
          in_valid  = 1'b1;
          ds = in_diff;
          x  = in_ovf ? (in_a_sign ? -32768 : 32767) : longint'(ds);
          if (s17 + x != clampv(s17 + x, 17)) sat17 = 1'b1;
          s24 = clampv(s24 + x, 24);
          s17 = clampv(s17 + x, 17);
          if (in_ovf) ocnt++;
          accepted++;
          phase++;
          if (phase == 4) begin
            e24 = s24; e17 = s17; esat17 = sat17; eocnt = ocnt;
            s24 = 0; s17 = 0; sat17 = 1'b0; ocnt = 0;
          end
        end
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("t6_pulses", pulses, 50);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
